// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Define RV_MC_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of retiring them as NOPs.
module rv_mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic [2:0]  imm_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [6:0] OP_OP = 7'b0110011, OP_IMM = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_BR = 7'b1100011,
    OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;
  state_t state_q, state_d;
  logic [6:0] opcode_q, opcode_d, op;
  logic illegal_q, illegal_d;
  logic [31:0] instret_q;
  logic is_ld, is_st, is_br, is_jmp, is_nop, is_legal;
  logic unused_instr;
  assign unused_instr = ^instr[31:7];
  // DECODE sees the opcode straight from the IR; later states use the latched copy
  assign op = (state_q == DECODE) ? instr[6:0] : opcode_q;
  assign is_ld = op == OP_LD;
  assign is_st = op == OP_ST;
  assign is_br = op == OP_BR;
  assign is_jmp = op == OP_JAL || op == OP_JALR;
  assign is_nop = op == OP_FENCE || op == OP_SYS;
  assign is_legal = is_ld || is_st || is_br || is_jmp || op == OP_OP || op == OP_IMM ||
                    op == OP_LUI || op == OP_AUIPC;
  assign state = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;
  assign imm_sel = (state_q == FETCH) ? 3'd7 :
                   (op == OP_IMM || is_ld || op == OP_JALR) ? 3'd0 :
                   is_st ? 3'd1 :
                   is_br ? 3'd2 :
                   (op == OP_LUI || op == OP_AUIPC) ? 3'd3 :
                   (op == OP_JAL) ? 3'd4 : 3'd7;
  always_comb begin
    state_d = state_q;
    opcode_d = opcode_q;
    illegal_d = illegal_q;
    mem_req = 1'b0;
    mem_we = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_sel = 1'b0;
    reg_we = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        ir_we = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        opcode_d = instr[6:0];
        if (is_legal) state_d = EXEC;
        else if (is_nop) begin
          pc_we = 1'b1;
          state_d = FETCH;
        end else begin
          illegal_d = 1'b1;
`ifdef RV_MC_ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          pc_we = 1'b1;
          state_d = FETCH;
`endif
        end
      end
      EXEC: begin
        if (is_br || is_jmp) begin
          pc_we = 1'b1;
          pc_sel = is_jmp | branch_taken;
          reg_we = is_jmp;
          state_d = FETCH;
        end else state_d = (is_ld || is_st) ? MEM : WB;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we = is_st;
        pc_we = mem_ready & is_st;
        if (mem_ready) state_d = is_st ? FETCH : WB;
      end
      WB: begin
        reg_we = 1'b1;
        pc_we = 1'b1;
        state_d = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
    // keep the memory port quiet while reset is held
    if (rst) begin
      mem_req = 1'b0;
      mem_we = 1'b0;
      ir_we = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      opcode_q <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      opcode_q <= opcode_d;
      illegal_q <= illegal_d;
      if (pc_we) instret_q <= instret_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_rv_mc_ctrl.sv
// tb_rv_mc_ctrl: scoreboard bench for rv_mc_ctrl; expected per-cycle control vectors are queued as stimulus is driven.
module tb_rv_mc_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] instr = '0;
  logic mem_ready = 1'b0, branch_taken = 1'b0;
  logic mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, illegal;
  logic [2:0] imm_sel, state;
  logic [31:0] instret;
  int n_tests = 0, n_fail = 0;
  logic [11:0] sb_q[$];
  string tag_q[$];
  logic [31:0] exp_ret = '0;
  rv_mc_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .reg_we(reg_we), .imm_sel(imm_sel), .state(state), .illegal(illegal), .instret(instret)
  );
  always #5 clk = ~clk;
  wire [11:0] act_v = {state, mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, imm_sel};
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  // vector layout: {state, mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, imm_sel}
  function automatic logic [11:0] ev(input int st, input bit req, input bit we, input bit ir,
                                     input bit pc, input bit ps, input bit rw, input int imm);
    return {3'(st), req, we, ir, pc, ps, rw, 3'(imm)};
  endfunction
  always @(negedge clk) begin
    #2;
    if (sb_q.size() != 0) chk(tag_q.pop_front(), 32'(act_v), 32'(sb_q.pop_front()));
  end
  task automatic cyc(input string tag, input bit rdy, input bit bt, input logic [11:0] e);
    @(negedge clk);
    mem_ready = rdy;
    branch_taken = bt;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask
  task automatic fetch(input string tag, input logic [31:0] v, input int waits);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      instr = v;
      mem_ready = (i == waits);
      branch_taken = 1'b0;
      sb_q.push_back(ev(0, 1, 0, i == waits, 0, 0, 0, 7));
      tag_q.push_back(tag);
    end
  endtask
  task automatic ret_chk(input string tag);
    @(posedge clk);
    #1;
    chk(tag, instret, exp_ret);
  endtask
  task automatic do_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_instret", instret, 0);
    chk("rst_illegal", 32'(illegal), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_req", 32'(mem_req), 1);
    exp_ret = '0;
  endtask
  initial begin
    @(negedge clk);
    #1;
    chk("init_state", 32'(state), 0);
    chk("init_req", 32'(mem_req), 0);
    chk("init_instret", instret, 0);
    chk("init_illegal", 32'(illegal), 0);
    rst = 1'b0;
    #1;
    chk("init_rel_req", 32'(mem_req), 1);
    fetch("addi_f", 32'h00500093, 0);
    cyc("addi_d", 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0));
    cyc("addi_e", 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 0));
    cyc("addi_wb", 0, 0, ev(4, 0, 0, 0, 1, 0, 1, 0));
    exp_ret++;
    ret_chk("addi_ret");
    fetch("lw_f", 32'h00002103, 1);
    cyc("lw_d", 1, 0, ev(1, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw_e", 1, 0, ev(2, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc("lw_mwait", 0, 0, ev(3, 1, 0, 0, 0, 0, 0, 0));
    cyc("lw_m", 1, 0, ev(3, 1, 0, 0, 0, 0, 0, 0));
    cyc("lw_wb", 0, 0, ev(4, 0, 0, 0, 1, 0, 1, 0));
    exp_ret++;
    ret_chk("lw_ret");
    fetch("sw_f", 32'h00202023, 0);
    cyc("sw_d", 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 1));
    cyc("sw_e", 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 1));
    cyc("sw_mwait", 0, 0, ev(3, 1, 1, 0, 0, 0, 0, 1));
    cyc("sw_m", 1, 0, ev(3, 1, 1, 0, 1, 0, 0, 1));
    exp_ret++;
    ret_chk("sw_ret");
    for (int t = 1; t >= 0; t--) begin
      fetch("beq_f", 32'h00000063, 0);
      cyc("beq_d", 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 2));
      cyc("beq_e", 0, t[0], ev(2, 0, 0, 0, 1, t[0], 0, 2));
      exp_ret++;
      ret_chk("beq_ret");
    end
    fetch("jal_f", 32'h0000006F, 0);
    cyc("jal_d", 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 4));
    cyc("jal_e", 0, 0, ev(2, 0, 0, 0, 1, 1, 1, 4));
    exp_ret++;
    ret_chk("jal_ret");
    fetch("jalr_f", 32'h00008067, 0);
    cyc("jalr_d", 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0));
    cyc("jalr_e", 0, 0, ev(2, 0, 0, 0, 1, 1, 1, 0));
    exp_ret++;
    ret_chk("jalr_ret");
    fetch("lui_f", 32'h000010b7, 0);
    cyc("lui_d", 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 3));
    cyc("lui_e", 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 3));
    cyc("lui_wb", 0, 0, ev(4, 0, 0, 0, 1, 0, 1, 3));
    exp_ret++;
    ret_chk("lui_ret");
    fetch("op_f", 32'h002081b3, 0);
    cyc("op_d", 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 7));
    cyc("op_e", 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 7));
    cyc("op_wb", 0, 0, ev(4, 0, 0, 0, 1, 0, 1, 7));
    exp_ret++;
    ret_chk("op_ret");
    fetch("fence_f", 32'h0000000F, 0);
    cyc("fence_d", 0, 0, ev(1, 0, 0, 0, 1, 0, 0, 7));
    exp_ret++;
    ret_chk("fence_ret");
    fetch("ill_f", 32'h00000000, 0);
`ifdef RV_MC_ILLEGAL_TRAP_EN
    cyc("ill_d", 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 7));
    for (int i = 0; i < 3; i++) cyc("ill_trap", 1, 1, ev(5, 0, 0, 0, 0, 0, 0, 7));
`else
    cyc("ill_d", 0, 0, ev(1, 0, 0, 0, 1, 0, 0, 7));
    exp_ret++;
`endif
    ret_chk("ill_ret");
    chk("ill_flag", 32'(illegal), 1);
    do_reset();
    fetch("addi2_f", 32'h00500093, 0);
    cyc("addi2_d", 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0));
    cyc("addi2_e", 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 0));
    cyc("addi2_wb", 0, 0, ev(4, 0, 0, 0, 1, 0, 1, 0));
    exp_ret++;
    ret_chk("addi2_ret");
    fetch("lwr_f", 32'h00002103, 0);
    cyc("lwr_d", 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0));
    cyc("lwr_e", 0, 0, ev(2, 0, 0, 0, 0, 0, 0, 0));
    cyc("lwr_m", 0, 0, ev(3, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #3;
    chk("mid_state_pre", 32'(state), 3);
    chk("mid_ret_pre", instret, 1);
    rst = 1'b1;
    #1;
    chk("mid_state", 32'(state), 0);
    chk("mid_pc_we", 32'(pc_we), 0);
    chk("mid_reg_we", 32'(reg_we), 0);
    chk("mid_req", 32'(mem_req), 0);
    @(posedge clk);
    #1;
    chk("mid_reg_we_hold", 32'(reg_we), 0);
    chk("mid_ret", instret, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_req", 32'(mem_req), 1);
    @(negedge clk);
    force dut.instret_q = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    release dut.instret_q;
    chk("wrap_pre", instret, 32'hFFFFFFFF);
    fetch("wrap_f", 32'h0000000F, 0);
    cyc("wrap_d", 0, 0, ev(1, 0, 0, 0, 1, 0, 0, 7));
    exp_ret = '0;
    ret_chk("wrap_ret");
    @(negedge clk);
    #3;
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
